// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode enum, default resolution and duty saturation helper for PWM blocks
package pwm_pkg;
  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
  localparam int PWM_R = 8;
  localparam int PWM_DW = PWM_R + 1;
  function automatic logic [31:0] sat_duty(input logic [31:0] d, input int r);
    return (d > (32'd1 << r)) ? (32'd1 << r) : d;
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: free-running clock divider producing one tick every final_value+1 clocks
module pwm_prescaler #(
  parameter int TIMER = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [TIMER-1:0] final_value,
  output logic             tick
);
  logic [TIMER-1:0] r_presc;
  // >= lets a lowered terminal count wrap immediately instead of running to overflow
  assign tick = enable && (r_presc >= final_value);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_presc <= '0;
    else r_presc <= (!enable || tick) ? '0 : r_presc + 1'b1;
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CH-channel edge/center-aligned PWM with double-buffered duty and mode
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int R     = PWM_DW - 1,
  parameter int TIMER = 16,
  parameter int CH    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [TIMER-1:0]  final_value,
  input  logic [CH*(R+1)-1:0] duty,
  input  logic              center_mode,
  output logic [CH-1:0]     pwm_out,
  output logic              period_tick
);
  localparam int DW = R + 1;
  logic         w_tick;
  logic         w_max;
  logic         w_bound;
  logic [R-1:0] r_cnt;
  logic         r_down;
  logic         r_ptick;
  pwm_mode_e    r_mode;
  pwm_prescaler #(.TIMER(TIMER)) u_presc (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .final_value(final_value),
    .tick(w_tick)
  );
  assign w_max = &r_cnt;
  assign w_bound = w_tick && ((r_mode == PWM_CENTER) ? (r_down && r_cnt == '0) : w_max);
  assign period_tick = r_ptick;
  // center mode holds cnt for one extra tick at the top (direction flip) and at the bottom (boundary)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt  <= '0;
      r_down <= 1'b0;
    end else if (!enable || w_bound) begin
      r_cnt  <= '0;
      r_down <= 1'b0;
    end else if (w_tick) begin
      if (r_mode == PWM_CENTER && r_down) r_cnt <= r_cnt - 1'b1;
      else if (r_mode == PWM_CENTER && w_max) r_down <= 1'b1;
      else r_cnt <= r_cnt + 1'b1;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_mode  <= PWM_EDGE;
      r_ptick <= 1'b0;
    end else begin
      r_ptick <= w_bound;
      if (!enable || w_bound) r_mode <= center_mode ? PWM_CENTER : PWM_EDGE;
    end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [R:0] w_sat;
    logic [R:0] r_duty;
    logic       r_pwm;
    assign w_sat = DW'(sat_duty(32'(duty[i*DW +: DW]), R));
    assign pwm_out[i] = r_pwm;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        r_duty <= '0;
        r_pwm  <= 1'b0;
      end else begin
        r_pwm <= enable && ({1'b0, r_cnt} < r_duty);
        if (!enable || w_bound) r_duty <= w_sat;
      end
  end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: table-driven and scoreboarded checks of pwm_multi high-time, period and corner cases
module tb_pwm_multi;
  localparam int R = 8, TIMER = 16, CH = 4;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        center_mode = 1'b0;
  logic [15:0] final_value = '0;
  logic [35:0] duty = '0;
  logic [3:0]  pwm_out;
  logic        period_tick;
  typedef struct packed {
    logic [15:0]      fv;
    logic             cm;
    logic [35:0]      duty;
    logic [3:0][10:0] hi;
    logic [10:0]      p;
  } vec_t;
  vec_t sbq[$];
  vec_t vecs[5];
  int checks = 0;
  int failures = 0;
  int hi_cnt[4];
  int pt_cnt, pt_last;

  pwm_multi #(.R(R), .TIMER(TIMER), .CH(CH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .final_value(final_value),
    .duty(duty),
    .center_mode(center_mode),
    .pwm_out(pwm_out),
    .period_tick(period_tick)
  );

  always #10 clk = ~clk;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(int fv, int cm, int d0, int d1, int d2, int d3,
                              int h0, int h1, int h2, int h3, int p);
    vec_t v;
    v.fv = 16'(fv);
    v.cm = 1'(cm);
    v.duty = {9'(d3), 9'(d2), 9'(d1), 9'(d0)};
    v.hi = {11'(h3), 11'(h2), 11'(h1), 11'(h0)};
    v.p = 11'(p);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start(input vec_t v);
    @(negedge clk);
    enable = 1'b0;
    final_value = v.fv;
    center_mode = v.cm;
    duty = v.duty;
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic measure(input int p, input int chg_at, input logic [35:0] nd, input logic ncm);
    for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
    pt_cnt = 0;
    pt_last = -1;
    for (int k = 0; k < p; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) if (pwm_out[c]) hi_cnt[c]++;
      if (period_tick) begin
        pt_cnt++;
        pt_last = k;
      end
      if (k == chg_at) begin
        duty = nd;
        center_mode = ncm;
      end
    end
  endtask

  task automatic check_sb(input string tag);
    vec_t e;
    if (sbq.size() == 0) begin
      chk({tag, " scoreboard empty"}, 0, 1);
      return;
    end
    e = sbq.pop_front();
    for (int c = 0; c < 4; c++) chk($sformatf("%s ch%0d high clocks", tag, c), hi_cnt[c], int'(e.hi[c]));
    chk({tag, " period_tick count"}, pt_cnt, 1);
    chk({tag, " period_tick position"}, pt_last, int'(e.p) - 1);
  endtask

  initial begin
    vecs[0] = mk(0, 0, 0, 64, 128, 256, 0, 64, 128, 256, 256);
    vecs[1] = mk(0, 1, 64, 64, 64, 64, 128, 128, 128, 128, 512);
    vecs[2] = mk(0, 0, 10, 20, 300, 511, 10, 20, 256, 256, 256);
    vecs[3] = mk(3, 0, 128, 0, 256, 1, 512, 0, 1024, 4, 1024);
    vecs[4] = mk(1, 1, 0, 1, 255, 256, 0, 4, 1020, 1024, 1024);

    #5;
    chk("reset pwm_out", int'(pwm_out), 0);
    chk("reset period_tick", int'(period_tick), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      start(vecs[i]);
      sbq.push_back(vecs[i]);
      measure(int'(vecs[i].p), -1, vecs[i].duty, vecs[i].cm);
      check_sb($sformatf("vec%0d", i));
    end

    // duty and mode changes mid-period only take effect at the next boundary
    start(mk(0, 0, 64, 0, 0, 0, 0, 0, 0, 0, 256));
    sbq.push_back(mk(0, 0, 64, 0, 0, 0, 64, 0, 0, 0, 256));
    measure(256, 100, {27'd0, 9'd192}, 1'b0);
    check_sb("update p1");
    sbq.push_back(mk(0, 0, 192, 0, 0, 0, 192, 0, 0, 0, 256));
    measure(256, 100, {27'd0, 9'd192}, 1'b1);
    check_sb("update p2");
    sbq.push_back(mk(0, 1, 192, 0, 0, 0, 384, 0, 0, 0, 512));
    measure(512, -1, {27'd0, 9'd192}, 1'b1);
    check_sb("mode p3");

    start(mk(0, 0, 256, 1, 0, 0, 0, 0, 0, 0, 256));
    repeat (50) @(posedge clk);
    #1;
    chk("running ch0 high", int'(pwm_out[0]), 1);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("disable pwm_out", int'(pwm_out), 0);
    chk("disable period_tick", int'(period_tick), 0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("reenable cnt0 outputs", int'(pwm_out), 3);
    @(posedge clk);
    #1;
    chk("reenable cnt1 outputs", int'(pwm_out), 1);
    measure(254, -1, duty, 1'b0);
    chk("reenable period_tick position", pt_last, 253);
    chk("reenable ch1 rest of period", hi_cnt[1], 0);

    repeat (20) @(posedge clk);
    #1;
    chk("pre-reset ch0 high", int'(pwm_out[0]), 1);
    #5;
    reset_n = 1'b0;
    #1;
    chk("async reset pwm_out", int'(pwm_out), 0);
    chk("async reset period_tick", int'(period_tick), 0);
    @(negedge clk);
    reset_n = 1'b1;
    sbq.push_back(mk(0, 0, 256, 1, 0, 0, 0, 0, 0, 0, 256));
    measure(256, -1, duty, 1'b0);
    check_sb("post-reset p1");
    sbq.push_back(mk(0, 0, 256, 1, 0, 0, 256, 1, 0, 0, 256));
    measure(256, -1, duty, 1'b0);
    check_sb("post-reset p2");

    // lowering final_value below the running count wraps on the next clock
    @(negedge clk);
    enable = 1'b0;
    final_value = 16'd200;
    @(negedge clk);
    enable = 1'b1;
    repeat (150) @(posedge clk);
    @(negedge clk);
    chk("presc=150 no tick", int'(dut.w_tick), 0);
    final_value = 16'd5;
    #1;
    chk("lowered fv immediate tick", int'(dut.w_tick), 1);
    for (int m = 1; m <= 12; m++) begin
      @(posedge clk);
      #1;
      chk($sformatf("fv5 tick clk%0d", m), int'(dut.w_tick), (m % 6 == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
